// File: rtl/pwm_analyzer_pkg.sv
// Shared types and helpers for the multi-channel RC PWM analyzer.
// Optional failsafe build switch: PWM_ANALYZER_FAILSAFE_EN.
package pwm_analyzer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pwm_state_e;

    localparam logic CLASS_LOW  = 1'b0;
    localparam logic CLASS_HIGH = 1'b1;

    // Hysteresis classification: outside the band decides, inside the band holds.
    function automatic logic classify(input int width, input int high_thr,
                                      input int low_thr, input logic prev);
        logic result;
        result = prev;
        if (width > high_thr) begin
            result = CLASS_HIGH;
        end else if (width < low_thr) begin
            result = CLASS_LOW;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_analyzer_channel.sv
// One RC pulse channel: synchronizer, edge detect, width measurement and
// hysteresis classification. Failsafe timeout is compiled in only when
// PWM_ANALYZER_FAILSAFE_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for a rising edge of the synchronized input
// MEASURE | input high, width counter running (saturating)
module pwm_analyzer_channel
    import pwm_analyzer_pkg::*;
#(
    parameter int MAX_COUNTER_VALUE  = 2000,
    parameter int HIGH_COUNTER_VALUE = 1900,
    parameter int LOW_COUNTER_VALUE  = 1100,
    parameter int TIMEOUT_CYCLES     = 50000,
    parameter int FAILSAFE_VALUE     = 0,
    parameter int CNT_W              = $clog2(MAX_COUNTER_VALUE + 1)
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    output logic             output_pin_o,
    output logic [CNT_W-1:0] width_o,
    output logic             pulse_valid_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNTER_VALUE);

    if (TIMEOUT_CYCLES < 1 || FAILSAFE_VALUE < 0 || FAILSAFE_VALUE > 1) begin : g_bad_failsafe_cfg
        $error("pwm_analyzer_channel: TIMEOUT_CYCLES must be >= 1 and FAILSAFE_VALUE 0 or 1");
    end

    logic [1:0]       sync_q;
    logic             level_prev_q;
    logic             rise;
    logic             fall;
    pwm_state_e       state_q;
    pwm_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_done;
    logic             out_q;
    logic             out_d;
    logic [CNT_W-1:0] width_q;
    logic             valid_q;

    // Two-flop synchronizer plus previous-sample register for edge detection.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q       <= 2'b00;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], enable_i};
            level_prev_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~level_prev_q;
    assign fall = ~sync_q[1] & level_prev_q;

    // FSM state and width counter registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load 1 on rise, count while high, finish on fall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_d    = IDLE;
                    pulse_done = 1'b1;
                end else if (sync_q[1] && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PWM_ANALYZER_FAILSAFE_EN
    localparam int              TO_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX       = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_TRIP      = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic            FAILSAFE_LVL = (FAILSAFE_VALUE != 0);

    logic [TO_W-1:0] idle_cnt_q;
    logic            timeout_q;
    logic            trip;

    // Trip only on the step that reaches the limit so a saturated counter
    // cannot re-trip right after the completed pulse that cleared it.
    assign trip = ~rise && (idle_cnt_q == TO_TRIP);

    // Cycles since the last rising edge, and the failsafe flag.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (rise) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != TO_MAX) begin
                idle_cnt_q <= idle_cnt_q + TO_W'(1);
            end
            if (trip) begin
                timeout_q <= 1'b1;
            end else if (pulse_done) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Output level: classify completed pulses, failsafe overrides.
    always_comb begin
        out_d = out_q;
        if (pulse_done) begin
            out_d = classify(int'(cnt_q), HIGH_COUNTER_VALUE, LOW_COUNTER_VALUE, out_q);
        end
`ifdef PWM_ANALYZER_FAILSAFE_EN
        if (trip) begin
            out_d = FAILSAFE_LVL;
        end
`endif
    end

    // Published results and one-cycle update strobe.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_q   <= 1'b0;
            width_q <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= pulse_done;
            if (pulse_done) begin
                width_q <= cnt_q;
            end
        end
    end

    assign output_pin_o  = out_q;
    assign width_o       = width_q;
    assign pulse_valid_o = valid_q;

endmodule

// File: rtl/pwm_analyzer_multi.sv
// Multi-channel RC PWM analyzer: CHANNELS independent measurement channels
// with packed outputs. Failsafe timeout enabled by PWM_ANALYZER_FAILSAFE_EN.
module pwm_analyzer_multi
    import pwm_analyzer_pkg::*;
#(
    parameter int CHANNELS           = 4,
    parameter int MAX_COUNTER_VALUE  = 2000,
    parameter int HIGH_COUNTER_VALUE = 1900,
    parameter int LOW_COUNTER_VALUE  = 1100,
    parameter int TIMEOUT_CYCLES     = 50000,
    parameter int FAILSAFE_VALUE     = 0,
    localparam int CNT_W             = $clog2(MAX_COUNTER_VALUE + 1)
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic [CHANNELS-1:0]       enable_i,
    output logic [CHANNELS-1:0]       output_pin_o,
    output logic [CHANNELS*CNT_W-1:0] width_o,
    output logic [CHANNELS-1:0]       pulse_valid_o,
    output logic [CHANNELS-1:0]       timeout_o
);

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("pwm_analyzer_multi: CHANNELS must be 1..8");
    end

    if (!(LOW_COUNTER_VALUE < HIGH_COUNTER_VALUE && HIGH_COUNTER_VALUE <= MAX_COUNTER_VALUE)) begin : g_bad_thresholds
        $error("pwm_analyzer_multi: need LOW < HIGH <= MAX");
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        pwm_analyzer_channel #(
            .MAX_COUNTER_VALUE  (MAX_COUNTER_VALUE),
            .HIGH_COUNTER_VALUE (HIGH_COUNTER_VALUE),
            .LOW_COUNTER_VALUE  (LOW_COUNTER_VALUE),
            .TIMEOUT_CYCLES     (TIMEOUT_CYCLES),
            .FAILSAFE_VALUE     (FAILSAFE_VALUE),
            .CNT_W              (CNT_W)
        ) u_channel (
            .clock_i       (clock_i),
            .reset_n_i     (reset_n_i),
            .enable_i      (enable_i[n]),
            .output_pin_o  (output_pin_o[n]),
            .width_o       (width_o[n*CNT_W +: CNT_W]),
            .pulse_valid_o (pulse_valid_o[n]),
            .timeout_o     (timeout_o[n])
        );
    end

endmodule

// File: tb/tb_pwm_analyzer_multi.sv
// Testbench for pwm_analyzer_multi. Failsafe scenarios are included when
// PWM_ANALYZER_FAILSAFE_EN is defined (timeout shortened to keep runs short).
module tb_pwm_analyzer_multi;

    localparam int CH    = 4;
    localparam int MAXV  = 2000;
    localparam int HIGHV = 1900;
    localparam int LOWV  = 1100;
    localparam int TOV   = 3000;
    localparam int FSV   = 0;
    localparam int CW    = $clog2(MAXV + 1);

    typedef int warr_t [CH];

    logic             clock_i   = 1'b0;
    logic             reset_n_i = 1'b0;
    logic [CH-1:0]    enable_i  = '0;
    logic [CH-1:0]    output_pin_o;
    logic [CH*CW-1:0] width_o;
    logic [CH-1:0]    pulse_valid_o;
    logic [CH-1:0]    timeout_o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   strb_cnt [CH] = '{default: 0};

    // reference model state
    logic m_out [CH];
    logic m_to [CH];
    int   m_w [CH];
    int   last_rise [CH];
    int   rise_cyc;

    pwm_analyzer_multi #(
        .CHANNELS           (CH),
        .MAX_COUNTER_VALUE  (MAXV),
        .HIGH_COUNTER_VALUE (HIGHV),
        .LOW_COUNTER_VALUE  (LOWV),
        .TIMEOUT_CYCLES     (TOV),
        .FAILSAFE_VALUE     (FSV)
    ) dut (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .enable_i      (enable_i),
        .output_pin_o  (output_pin_o),
        .width_o       (width_o),
        .pulse_valid_o (pulse_valid_o),
        .timeout_o     (timeout_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc <= cyc + 1;

    always @(negedge clock_i) begin
        for (int c = 0; c < CH; c++) begin
            if (pulse_valid_o[c]) strb_cnt[c] <= strb_cnt[c] + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [CW-1:0] w_of(input int c);
        return width_o[c*CW +: CW];
    endfunction

    // Expected level after a completed pulse of raw high-time w.
    function automatic logic exp_cls(input int w, input logic prev);
        int m;
        m = (w > MAXV) ? MAXV : w;
        if (m > HIGHV) return 1'b1;
        if (m < LOWV) return 1'b0;
        return prev;
    endfunction

    function automatic warr_t ch0_only(input int w);
        warr_t r;
        for (int c = 0; c < CH; c++) r[c] = 0;
        r[0] = w;
        return r;
    endfunction

    function automatic int rand_w();
        int bl [9];
        int sel;
        bl = '{1, 1099, 1100, 1101, 1899, 1900, 1901, 2000, 2001};
        sel = $urandom_range(0, 9);
        if (sel == 0) return 0;
        if (sel <= 3) return bl[$urandom_range(0, 8)];
        return $urandom_range(1, 2300);
    endfunction

    // Drive one pulse per channel (0 = no pulse), all rising together, then check.
    task automatic drive_group(input warr_t w, input string tag);
        int   wmax;
        int   s0 [CH];
        logic prev;
        wmax = 0;
        for (int c = 0; c < CH; c++) begin
            s0[c] = strb_cnt[c];
            if (w[c] > wmax) wmax = w[c];
        end
        @(posedge clock_i); #1;
        rise_cyc = cyc;
        for (int c = 0; c < CH; c++) if (w[c] > 0) enable_i[c] = 1'b1;
        for (int t = 1; t <= wmax; t++) begin
            @(posedge clock_i); #1;
            for (int c = 0; c < CH; c++) if (w[c] == t) enable_i[c] = 1'b0;
        end
        repeat (6) @(posedge clock_i);
        #1;
        for (int c = 0; c < CH; c++) begin
            if (w[c] > 0) begin
                prev = m_out[c];
`ifdef PWM_ANALYZER_FAILSAFE_EN
                if (rise_cyc - last_rise[c] > TOV) prev = (FSV != 0);
`endif
                m_out[c]     = exp_cls(w[c], prev);
                m_w[c]       = (w[c] > MAXV) ? MAXV : w[c];
                m_to[c]      = 1'b0;
                last_rise[c] = rise_cyc;
                chk($sformatf("%s_strobe_ch%0d", tag, c), 32'(strb_cnt[c] - s0[c]), 32'd1);
            end else begin
`ifdef PWM_ANALYZER_FAILSAFE_EN
                if (cyc - last_rise[c] >= TOV + 3) begin
                    m_out[c] = (FSV != 0);
                    m_to[c]  = 1'b1;
                end
`endif
                chk($sformatf("%s_nostrobe_ch%0d", tag, c), 32'(strb_cnt[c] - s0[c]), 32'd0);
            end
            chk($sformatf("%s_width_ch%0d", tag, c), 32'(w_of(c)), 32'(m_w[c]));
            chk($sformatf("%s_out_ch%0d", tag, c), 32'(output_pin_o[c]), 32'(m_out[c]));
            chk($sformatf("%s_timeout_ch%0d", tag, c), 32'(timeout_o[c]), 32'(m_to[c]));
        end
    endtask

    initial begin
        int    er;
        int    s0;
        int    k;
        int    wdur;
        int    s_all [CH];
        warr_t wv;

        for (int c = 0; c < CH; c++) begin
            m_out[c] = 1'b0; m_to[c] = 1'b0; m_w[c] = 0; last_rise[c] = 0;
        end

        // reset held for 200 cycles
        repeat (100) @(posedge clock_i);
        #1;
        chk("rst_out", 32'(output_pin_o), 32'd0);
        chk("rst_width_any", 32'(|width_o), 32'd0);
        chk("rst_valid", 32'(pulse_valid_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        repeat (100) @(posedge clock_i);
        #1;
        reset_n_i = 1'b1;
        er = cyc;
        for (int c = 0; c < CH; c++) last_rise[c] = er - 3;

        // first pulse with exact strobe latency
        @(posedge clock_i); #1;
        rise_cyc = cyc;
        enable_i[0] = 1'b1;
        repeat (2000) @(posedge clock_i);
        #1;
        enable_i[0] = 1'b0;
        s0 = strb_cnt[0];
        @(posedge clock_i); #1;
        chk("lat_edge1_valid", 32'(pulse_valid_o[0]), 32'd0);
        @(posedge clock_i); #1;
        chk("lat_edge2_valid", 32'(pulse_valid_o[0]), 32'd0);
        @(posedge clock_i); #1;
        chk("lat_edge3_valid", 32'(pulse_valid_o[0]), 32'd1);
        chk("lat_edge3_width", 32'(w_of(0)), 32'd2000);
        chk("lat_edge3_out", 32'(output_pin_o[0]), 32'd1);
        @(posedge clock_i); #1;
        chk("lat_edge4_valid", 32'(pulse_valid_o[0]), 32'd0);
        chk("lat_strobe_count", 32'(strb_cnt[0] - s0), 32'd1);
        m_out[0] = 1'b1; m_w[0] = 2000; last_rise[0] = rise_cyc;

        // hysteresis sequence on ch0
        drive_group(ch0_only(1000), "seq1000");
        drive_group(ch0_only(1950), "seq1950");
        drive_group(ch0_only(1400), "seq1400");
        drive_group(ch0_only(1050), "seq1050");
        drive_group(ch0_only(1500), "seq1500");
        drive_group(ch0_only(2500), "sat2500");

        // all channels at once, then threshold boundaries
        wv = '{1000, 1500, 2000, 1200};
        drive_group(wv, "allch");
        wv = '{1100, 1900, 1901, 1099};
        drive_group(wv, "bound");

        // randomized groups
        for (int g = 0; g < 10; g++) begin
            for (int c = 0; c < CH; c++) wv[c] = rand_w();
            drive_group(wv, $sformatf("rnd%0d", g));
        end

        // reset mid-pulse, input still high at release
        @(posedge clock_i); #1;
        enable_i = '1;
        repeat (700) @(posedge clock_i);
        #1;
        reset_n_i = 1'b0;
        #1;
        chk("midrst_out", 32'(output_pin_o), 32'd0);
        chk("midrst_width_any", 32'(|width_o), 32'd0);
        chk("midrst_valid", 32'(pulse_valid_o), 32'd0);
        chk("midrst_timeout", 32'(timeout_o), 32'd0);
        repeat (10) @(posedge clock_i);
        #1;
        reset_n_i = 1'b1;
        er = cyc;
        for (int c = 0; c < CH; c++) s_all[c] = strb_cnt[c];
        repeat (790) @(posedge clock_i);
        #1;
        enable_i = '0;
        repeat (6) @(posedge clock_i);
        #1;
        for (int c = 0; c < CH; c++) begin
            m_out[c] = exp_cls(790, 1'b0); m_w[c] = 790; m_to[c] = 1'b0; last_rise[c] = er;
            chk($sformatf("partial_strobe_ch%0d", c), 32'(strb_cnt[c] - s_all[c]), 32'd1);
            chk($sformatf("partial_width_ch%0d", c), 32'(w_of(c)), 32'd790);
            chk($sformatf("partial_out_ch%0d", c), 32'(output_pin_o[c]), 32'(m_out[c]));
        end

`ifdef PWM_ANALYZER_FAILSAFE_EN
        // stuck-low trip on every channel
        wv = '{1950, 1950, 1950, 1950};
        drive_group(wv, "fs_pre");
        k = 0;
        while (timeout_o !== '1 && k < TOV + 50) begin
            @(posedge clock_i); #1;
            k++;
        end
        chk("fs_low_trip_latency", 32'(cyc - rise_cyc), 32'(TOV + 3));
        chk("fs_low_timeout", 32'(timeout_o), 32'({CH{1'b1}}));
        chk("fs_low_out", 32'(output_pin_o), 32'({CH{FSV != 0}}));
        for (int c = 0; c < CH; c++) begin m_out[c] = (FSV != 0); m_to[c] = 1'b1; end
        drive_group(wv, "fs_recover");

        // stuck-high trip, then release gives a saturated pulse
        for (int c = 0; c < CH; c++) s_all[c] = strb_cnt[c];
        @(posedge clock_i); #1;
        rise_cyc = cyc;
        enable_i = '1;
        k = 0;
        while (timeout_o !== '1 && k < TOV + 50) begin
            @(posedge clock_i); #1;
            k++;
        end
        chk("fs_high_trip_latency", 32'(cyc - rise_cyc), 32'(TOV + 3));
        chk("fs_high_out", 32'(output_pin_o), 32'({CH{FSV != 0}}));
        enable_i = '0;
        wdur = cyc - rise_cyc;
        repeat (6) @(posedge clock_i);
        #1;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("fs_high_strobe_ch%0d", c), 32'(strb_cnt[c] - s_all[c]), 32'd1);
            chk($sformatf("fs_high_width_ch%0d", c), 32'(w_of(c)), 32'(wdur > MAXV ? MAXV : wdur));
            chk($sformatf("fs_high_out_ch%0d", c), 32'(output_pin_o[c]), 32'(exp_cls(wdur, FSV != 0)));
            chk($sformatf("fs_high_clear_ch%0d", c), 32'(timeout_o[c]), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
